// File: rtl/comparador_serial_pkg.sv
// Shared types and constants for the serial nibble comparator: FSM encoding,
// nibble width and the cascade seed value.
package comparador_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    INICIAL = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cascata_t;

  // Seed for a new comparison: "equal so far", so an all-equal walk ends in eq.
  localparam cascata_t CASCATA_RESET = '{lt: 1'b0, gt: 1'b0, eq: 1'b1};

endpackage

// File: rtl/comparador_85.sv
// One 4-bit cascadable magnitude-comparator stage: a differing nibble decides
// the order, an equal nibble passes the cascade inputs through.
module comparador_85
  import comparador_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  cascata_t            cascata_in,
  output cascata_t            cascata_out
);

  always_comb begin
    cascata_out = cascata_in;
    if (a < b) begin
      cascata_out = '{lt: 1'b1, gt: 1'b0, eq: 1'b0};
    end else if (a > b) begin
      cascata_out = '{lt: 1'b0, gt: 1'b1, eq: 1'b0};
    end
  end

endmodule

// File: rtl/comparador_serial_uc.sv
// Sequenced magnitude comparator: walks A and B one nibble per clock, LSB first,
// through a single comparador_85 stage. Optional signed mode: COMPARADOR_SINAL_EN.
module comparador_serial_uc
  import comparador_serial_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] A,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] B,
`ifdef COMPARADOR_SINAL_EN
  input  logic                          com_sinal,
`endif
  output logic                          ocupado,
  output logic                          pronto,
  output logic                          menor,
  output logic                          maior,
  output logic                          igual
);

  localparam int OP_W  = NIBBLE_W * N_NIBBLES;
  localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(N_NIBBLES - 1);

  estado_t               state_reg, state_next;
  logic [OP_W-1:0]       a_reg, b_reg;
  logic [IDX_W-1:0]      idx_reg;
  cascata_t              cascata_reg, cascata_step;
  logic                  menor_reg, maior_reg, igual_reg;
  logic [NIBBLE_W-1:0]   nib_a [N_NIBBLES];
  logic [NIBBLE_W-1:0]   nib_b [N_NIBBLES];
  logic [NIBBLE_W-1:0]   step_a, step_b;
  logic                  aceita, ultimo;
`ifdef COMPARADOR_SINAL_EN
  logic                  com_sinal_reg;
`endif

  generate
    for (genvar gi = 0; gi < N_NIBBLES; gi++) begin : g_nibble
      assign nib_a[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign nib_b[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  assign aceita = iniciar && ((state_reg == INICIAL) || (state_reg == FIM));
  assign ultimo = (idx_reg == IDX_ULTIMO);

  always_comb begin
    step_a = nib_a[idx_reg];
    step_b = nib_b[idx_reg];
`ifdef COMPARADOR_SINAL_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (ultimo && com_sinal_reg) begin
      step_a[NIBBLE_W-1] = ~step_a[NIBBLE_W-1];
      step_b[NIBBLE_W-1] = ~step_b[NIBBLE_W-1];
    end
`endif
  end

  comparador_85 u_estagio (
    .a           (step_a),
    .b           (step_b),
    .cascata_in  (cascata_reg),
    .cascata_out (cascata_step)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= INICIAL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INICIAL: if (iniciar) state_next = COMPARA;
      COMPARA: if (ultimo) state_next = FIM;
      FIM:     state_next = iniciar ? COMPARA : INICIAL;
      default: state_next = INICIAL;
    endcase
  end

  always_comb begin
    ocupado = (state_reg == COMPARA);
    pronto  = (state_reg == FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      idx_reg     <= '0;
      cascata_reg <= CASCATA_RESET;
      menor_reg   <= 1'b0;
      maior_reg   <= 1'b0;
      igual_reg   <= 1'b0;
`ifdef COMPARADOR_SINAL_EN
      com_sinal_reg <= 1'b0;
`endif
    end else if (aceita) begin
      a_reg       <= A;
      b_reg       <= B;
      idx_reg     <= '0;
      cascata_reg <= CASCATA_RESET;
      menor_reg   <= 1'b0;
      maior_reg   <= 1'b0;
      igual_reg   <= 1'b0;
`ifdef COMPARADOR_SINAL_EN
      com_sinal_reg <= com_sinal;
`endif
    end else if (state_reg == COMPARA) begin
      cascata_reg <= cascata_step;
      idx_reg     <= idx_reg + 1'b1;
      if (ultimo) begin
        menor_reg <= cascata_step.lt;
        maior_reg <= cascata_step.gt;
        igual_reg <= cascata_step.eq;
      end
    end
  end

  assign menor = menor_reg;
  assign maior = maior_reg;
  assign igual = igual_reg;

endmodule

// File: tb/tb_comparador_serial_uc.sv
// Directed self-checking bench for comparador_serial_uc (default N_NIBBLES=4);
// signed expectations apply when COMPARADOR_SINAL_EN is defined.
module tb_comparador_serial_uc;
  import comparador_serial_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        com_sinal = 1'b0;
  logic        ocupado, pronto, menor, maior, igual;

  int tests = 0;
  int fails = 0;

  comparador_serial_uc #(.N_NIBBLES(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .iniciar (iniciar),
    .A       (A),
    .B       (B),
`ifdef COMPARADOR_SINAL_EN
    .com_sinal (com_sinal),
`endif
    .ocupado (ocupado),
    .pronto  (pronto),
    .menor   (menor),
    .maior   (maior),
    .igual   (igual)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive a start for one edge with new operands.
  task automatic aceitar(input logic [15:0] a_v, input logic [15:0] b_v);
    A = a_v;
    B = b_v;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // Clocks until pronto; checks COMPARA outputs on the way. Gives up after 20.
  task automatic esperar_pronto(input string tag, output int n);
    n = 0;
    while (n < 20) begin
      tick();
      iniciar = 1'b0;
      n++;
      if (pronto) break;
      check({tag, "_compara"}, {ocupado, menor, maior, igual}, 4'b1000);
    end
  endtask

  int n;
  int extra;

  initial begin
    // Reset and idle.
    tick();
    tick();
    check("reset_outs", {ocupado, pronto, menor, maior, igual}, 5'b00000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_outs", {ocupado, pronto, menor, maior, igual}, 5'b00000);
    end

    // 1234 < 1235, then hold in INICIAL.
    aceitar(16'h1234, 16'h1235);
    check("t1_ocupado", {ocupado, pronto, menor, maior, igual}, 5'b10000);
    esperar_pronto("t1", n);
    check("t1_latencia", n, 4);
    check("t1_result", {ocupado, pronto, menor, maior, igual}, 5'b01100);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_hold", {ocupado, pronto, menor, maior, igual}, 5'b00100);
    end

    // 8000 vs 7FFF: unsigned gives maior, signed gives menor.
    com_sinal = 1'b1;
    aceitar(16'h8000, 16'h7FFF);
    com_sinal = 1'b0;
    esperar_pronto("t2", n);
    check("t2_latencia", n, 4);
`ifdef COMPARADOR_SINAL_EN
    check("t2_result", {menor, maior, igual}, 3'b100);
`else
    check("t2_result", {menor, maior, igual}, 3'b010);
`endif
    tick();

    // Equal operands, then back-to-back start held across FIM.
    aceitar(16'hABCD, 16'hABCD);
    esperar_pronto("t3", n);
    check("t3_latencia", n, 4);
    check("t3_result", {ocupado, pronto, menor, maior, igual}, 5'b01001);
    A = 16'h0001;
    B = 16'h0000;
    iniciar = 1'b1;
    esperar_pronto("t4", n);
    check("t4_intervalo", n, 5);
    check("t4_result", {ocupado, pronto, menor, maior, igual}, 5'b01010);
    tick();
    check("t4_inicial", {ocupado, pronto, menor, maior, igual}, 5'b00010);

    // Start ignored during COMPARA; operands stay latched.
    aceitar(16'h0005, 16'h0003);
    A = 16'h0000;
    B = 16'hFFFF;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("t5_ocupado", {ocupado, pronto, menor, maior, igual}, 5'b10000);
    esperar_pronto("t5", n);
    check("t5_latencia", n, 3);
    check("t5_result", {menor, maior, igual}, 3'b010);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pronto) extra++;
    end
    check("t5_pronto_extra", extra, 0);

    // Reset two cycles after acceptance aborts the comparison.
    aceitar(16'h0001, 16'h0002);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_estado", dut.state_reg, INICIAL);
    check("t6_outs", {ocupado, pronto, menor, maior, igual}, 5'b00000);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pronto || ocupado) extra++;
    end
    check("t6_sem_pronto", extra, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparador_serial_uc.md
# comparador_serial_uc

Sequencing controller that compares two multi-nibble unsigned operands using a single 4-bit cascadable magnitude-comparator stage. The operands are walked least-significant nibble first, and the stage's less/greater/equal outputs are fed back through registers into its cascade inputs. The block sits between the game control unit and the score/position datapath. It replaces a wide combinational comparator with N sequenced nibble steps.

## Interface
Parameters:
- N_NIBBLES, 4, number of 4-bit nibbles per operand; operand width is 4*N_NIBBLES, minimum 1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- iniciar  in  1  start request, level-sampled.
- A  in  4*N_NIBBLES  operand A, sampled only on the accepting edge.
- B  in  4*N_NIBBLES  operand B, sampled only on the accepting edge.
- ocupado  out  1  high while a comparison is in progress.
- pronto  out  1  one-cycle pulse when results become valid.
- menor  out  1  result: A < B.
- maior  out  1  result: A > B.
- igual  out  1  result: A == B.

## Operation
- FSM states:
  - INICIAL (reset state): idle; accepts a start.
  - COMPARA: processes one nibble per clock.
  - FIM: the pronto cycle; also accepts a start.
- Acceptance edge: iniciar=1 while in INICIAL or FIM.
  - A and B are latched into internal registers.
  - Nibble index is cleared to 0.
  - Cascade registers load (lt=0, gt=0, eq=1).
  - menor, maior and igual clear to 0.
  - State moves to COMPARA.
- iniciar is ignored in COMPARA. No queuing and no restart; the latched operands are unaffected.
- Each COMPARA edge performs one cascade step on nibble idx:
  - If the A nibble differs from the B nibble, the nibble order decides (lt, gt) and eq is cleared.
  - If the nibbles are equal, the cascade registers pass through unchanged.
  - idx increments.
- When the step processes idx = N_NIBBLES-1:
  - The final cascade values are written into menor, maior and igual.
  - State moves to FIM.
- FIM with iniciar=0 returns to INICIAL. FIM with iniciar=1 accepts a new comparison (back-to-back).
- Output invariant: exactly one of menor, maior, igual is high from FIM until the next acceptance edge or reset. All three are 0 during COMPARA.
- Outputs are held in INICIAL after a comparison until the next acceptance edge.
- Reset mid-operation forces INICIAL, discards the in-flight comparison, and produces no pronto.

## Timing
- Reset values: ocupado=0, pronto=0, menor=0, maior=0, igual=0, state=INICIAL, idx=0.
- Latency: for an acceptance at edge E0, results are registered at edge E(N_NIBBLES). pronto is high for the single cycle following that edge.
  - Default N_NIBBLES=4: pronto is high 4 clocks after acceptance.
- ocupado is high from the cycle after E0 through the cycle before FIM; it is low in FIM.
- pronto is a Moore output (state==FIM), registered and glitch-free.
- Back-to-back throughput: one result every N_NIBBLES+1 clocks.
- N_NIBBLES=1: COMPARA lasts exactly one cycle.

## Configuration
- COMPARADOR_SINAL_EN:
  - Defined: an extra input port com_sinal (1 bit) exists and is latched at acceptance. When the latched value is 1, bit 3 of the most-significant nibble of both latched operands is inverted before its step, giving two's-complement signed comparison. When 0, comparison is unsigned.
  - Undefined: no com_sinal port; comparison is always unsigned.
- Timing is identical in both builds.

## Structure
- Shared package comparador_serial_pkg holds:
  - state encodings INICIAL/COMPARA/FIM (2 bits);
  - nibble width constant 4;
  - cascade reset constant {lt=0, gt=0, eq=1}.
- One sub-module: comparador_85 instantiated once as the nibble stage. Its cascade inputs are driven from the cascade registers and its outputs feed those registers.
- The controller FSM, index counter, operand registers and result registers live in comparador_serial_uc.

## Test plan
- Reset, then idle 3 cycles. Required: all outputs 0 and no pronto.
- A=16'h1234, B=16'h1235, iniciar pulsed once. Required:
  - pronto exactly 4 clocks after acceptance;
  - menor=1, maior=0, igual=0, held for 10 idle cycles.
- A=16'h8000, B=16'h7FFF:
  - unsigned build: maior=1;
  - COMPARADOR_SINAL_EN build with com_sinal=1: menor=1.
- A=B=16'hABCD. Required: igual=1. Then iniciar held high across FIM with A=16'h0001, B=16'h0000. Required: second pronto 5 clocks after the first, with maior=1.
- Start a comparison, then change A/B and pulse iniciar during COMPARA. Required: the result reflects the original latched operands and there is exactly one pronto.
- Assert reset 2 cycles after acceptance. Required: INICIAL, all outputs 0, and no pronto for 8 subsequent cycles.
